hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32 core. It owns the stage-register enables and flushes around the forwarding datapath.
- Detects load-use hazards the forwarding paths cannot cover and inserts one bubble. Flushes wrong-path instructions on a taken branch.
- Freezes the front end while a multicycle mul/div unit is busy, with a start/done handshake and timeout.
- Sits in the core's control path between the ID/EX/MEM pipeline registers and the PC register.

---
 rtl/core_ctrl_pkg.sv | 14 +
 rtl/sat_counter.sv | 34 +++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared control-path types and constants for the pipeline sequencing logic.
package core_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_t;

    localparam int REG_ZERO = 0;

    // addi x0, x0, 0 -- what a flushed pipeline register loads
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !(&cnt_q)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use bubble, taken-branch flush, mul/div freeze.
module hazard_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_md_valid,
    input  logic             ex_branch_taken,
    input  logic             md_done,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_redirect,
    output logic             md_start,
    output logic             md_timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int TO_W = $clog2(MD_TIMEOUT) + 1;

    hz_state_t       state_q;
    hz_state_t       state_d;
    logic            err_q;
    logic            err_d;
    logic [TO_W-1:0] to_cnt;
    logic            to_en;
    logic            to_clr;
    logic            lu;
    logic            to_hit;

    always_comb begin
        lu = ex_mem_read && (ex_rd != REG_W'(REG_ZERO)) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) ||
              (id_use_rs2 && (id_rs2 == ex_rd)));
        to_hit = (to_cnt == TO_W'(MD_TIMEOUT - 1));
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_redirect  = 1'b0;
        md_start     = 1'b0;
        state_d      = state_q;
        err_d        = err_q;
        to_en        = 1'b0;
        to_clr       = 1'b0;
        // Held reset forces the pass-through defaults regardless of inputs
        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ex_md_valid) begin
                        md_start     = 1'b1;
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        to_clr       = 1'b1;
                        state_d      = MD_WAIT;
                    end else if (lu) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    to_en    = 1'b1;
                    if (md_done) begin
                        state_d = RUN;
                        to_clr  = 1'b1;
                    end else begin
                        ex_mem_flush = 1'b1;
                        if (to_hit) begin
                            err_d   = 1'b1;
                            state_d = RUN;
                            to_clr  = 1'b1;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.W(TO_W)) u_to_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (to_clr),
        .en    (to_en),
        .cnt   (to_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (!pc_en),
        .cnt   (stall_cycles)
    );

    assign md_timeout_err = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int MD_TO = 8;
    localparam int CNT_W = 6;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2;
    logic             ex_mem_read, ex_md_valid, ex_branch_taken, md_done;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush;
    logic             pc_redirect, md_start, md_timeout_err;
    logic [CNT_W-1:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_wait;
    int m_wait_no;
    bit m_err;
    int m_stalls;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_W(REG_W), .MD_TIMEOUT(MD_TO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_md_valid(ex_md_valid), .ex_branch_taken(ex_branch_taken),
        .md_done(md_done),
        .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .pc_redirect(pc_redirect),
        .md_start(md_start), .md_timeout_err(md_timeout_err),
        .stall_cycles(stall_cycles)
    );

    function automatic void chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model: compare this cycle's outputs, then advance to next cycle
    always @(negedge clk) begin
        bit e_pc, e_ifid, e_idex, e_exm, e_fif, e_fidex, e_fexm, e_red, e_st;
        bit lu, n_wait, n_err;
        e_pc = 1; e_ifid = 1; e_idex = 1; e_exm = 1;
        e_fif = 0; e_fidex = 0; e_fexm = 0; e_red = 0; e_st = 0;
        n_wait = m_wait;
        n_err = m_err;
        if (!rst_n) begin
            m_wait = 0; m_wait_no = 0; m_err = 0; m_stalls = 0;
            n_wait = 0; n_err = 0;
        end else if (!m_wait) begin
            lu = ex_mem_read && (ex_rd != 0) &&
                 ((id_use_rs1 && id_rs1 == ex_rd) ||
                  (id_use_rs2 && id_rs2 == ex_rd));
            if (ex_branch_taken) begin
                e_red = 1; e_fif = 1; e_fidex = 1;
            end else if (ex_md_valid) begin
                e_st = 1; e_pc = 0; e_ifid = 0; e_idex = 0; e_fexm = 1;
                n_wait = 1;
                m_wait_no = 0;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; e_fidex = 1;
            end
        end else begin
            e_pc = 0; e_ifid = 0; e_idex = 0;
            m_wait_no++;
            if (md_done) begin
                n_wait = 0;
            end else begin
                e_fexm = 1;
                if (m_wait_no == MD_TO) begin
                    n_err = 1;
                    n_wait = 0;
                end
            end
        end
        chk("ctrl{pc,ifid,idex,exm,fif,fidex,fexm,red,start}",
            {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
             id_ex_flush, ex_mem_flush, pc_redirect, md_start},
            {e_pc, e_ifid, e_idex, e_exm, e_fif,
             e_fidex, e_fexm, e_red, e_st});
        chk("stall_cycles", stall_cycles, m_stalls);
        chk("md_timeout_err", md_timeout_err, m_err);
        if (rst_n) begin
            m_wait = n_wait;
            m_err = n_err;
            if (!e_pc && m_stalls < SAT) m_stalls++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_mem_read = 0; ex_md_valid = 0;
        ex_branch_taken = 0; md_done = 0;
    endtask

    task automatic set_lu(input logic [REG_W-1:0] rd);
        ex_mem_read = 1; ex_rd = rd; id_rs2 = 5; id_use_rs2 = 1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (3) cyc();
        rst_n = 1;

        repeat (10) cyc();
        chk("idle_pc_en", pc_en, 1);
        chk("idle_stall", stall_cycles, 0);

        set_lu(5);
        #1;
        chk("lu_pc_en", pc_en, 0);
        chk("lu_id_ex_flush", id_ex_flush, 1);
        cyc();
        idle();
        #1;
        chk("lu_stall1", stall_cycles, 1);
        set_lu(0);
        #1;
        chk("lu_rd0_pc_en", pc_en, 1);
        cyc();
        idle();

        set_lu(5);
        ex_branch_taken = 1;
        #1;
        chk("br_lu_redirect", pc_redirect, 1);
        chk("br_lu_pc_en", pc_en, 1);
        chk("br_lu_if_id_flush", if_id_flush, 1);
        cyc();
        idle();
        #1;
        chk("br_lu_stall", stall_cycles, 1);

        ex_md_valid = 1;
        #1;
        chk("md_start", md_start, 1);
        cyc();
        ex_md_valid = 0;
        repeat (6) cyc();
        md_done = 1;
        #1;
        chk("md_done_exm_flush", ex_mem_flush, 0);
        chk("md_done_exm_en", ex_mem_en, 1);
        chk("md_done_pc_en", pc_en, 0);
        cyc();
        md_done = 0;
        #1;
        chk("md_back_run", pc_en, 1);
        chk("md_stall", stall_cycles, 9);

        ex_md_valid = 1;
        cyc();
        ex_md_valid = 0;
        repeat (7) cyc();
        chk("to_not_yet", md_timeout_err, 0);
        cyc();
        chk("to_err", md_timeout_err, 1);
        chk("to_run", pc_en, 1);
        chk("to_stall", stall_cycles, 18);
        repeat (5) cyc();
        chk("to_sticky", md_timeout_err, 1);

        ex_md_valid = 1;
        cyc();
        ex_md_valid = 0;
        repeat (2) cyc();
        rst_n = 0;
        #1;
        chk("rst_mid_pc_en", pc_en, 1);
        chk("rst_mid_stall", stall_cycles, 0);
        chk("rst_mid_err", md_timeout_err, 0);
        cyc();
        rst_n = 1;
        #1;
        chk("rst_rel_start", md_start, 0);
        repeat (4) cyc();
        chk("rst_rel_pc_en", pc_en, 1);

        for (int i = 0; i < 3000; i++) begin
            id_rs1 = REG_W'($urandom_range(0, 3));
            id_rs2 = REG_W'($urandom_range(0, 3));
            ex_rd = REG_W'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_use_rs2 = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            ex_md_valid = ($urandom_range(0, 19) == 0);
            ex_mem_read = !ex_md_valid && ($urandom_range(0, 1) == 1);
            md_done = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 0;
                cyc();
                rst_n = 1;
            end
            cyc();
        end
        idle();
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
